handshake_constant_buffered: RTL
================================

// Module: handshake_constant_buffered
// PURPOSE
//  Handshake constant source with a registered output stage: every token accepted on ctrl emits one
//  word of value CONST_VALUE on outs. A 2-slot elastic (skid) buffer breaks the combinational
//  ctrl_ready <- outs_ready path of the unregistered constant units and keeps full throughput.
//  Used where a constant feeds a long or high-fanout dataflow edge. Also counts emitted tokens.
// PARAMETERS
//  DATA_WIDTH   32      width of outs
//  CONST_VALUE  32'd12  emitted constant; zero-extended or truncated (LSBs kept) to DATA_WIDTH
//  CNT_WIDTH    16      width of emitted-token counter tok_count
// PORTS
//  clk         in   1           single clock, all state on rising edge
//  rst         in   1           reset: asynchronous, active-low (0 = reset)
//  ctrl_valid  in   1           control token present
//  ctrl_ready  out  1           block can accept a control token (registered)
//  outs        out  DATA_WIDTH  constant data, meaningful when outs_valid=1
//  outs_valid  out  1           output token present (registered)
//  outs_ready  in   1           consumer accepts output token
//  tok_count   out  CNT_WIDTH   number of output transfers since reset, mod 2^CNT_WIDTH
// BEHAVIOUR
//  - Transfer: ctrl_fire = ctrl_valid & ctrl_ready; outs_fire = outs_valid & outs_ready.
//  - State: occupancy occ in {EMPTY=0, ONE=1, FULL=2} (main slot + skid slot).
//  - Reset (rst=0, async assert, sync-safe deassert at clk edge): occ=EMPTY, outs_valid=0,
//    ctrl_ready=1, tok_count=0. outs drives CONST_VALUE at all times, including during reset.
//  - outs_valid = (occ != EMPTY); ctrl_ready = (occ != FULL); both come straight from flops,
//    no combinational path from outs_ready or ctrl_valid to any output.
//  - Transitions per cycle (a=ctrl_fire, d=outs_fire):
//      EMPTY: a -> ONE; else stay (d impossible).
//      ONE:   a&!d -> FULL; !a&d -> EMPTY; a&d or !a&!d -> stay ONE.
//      FULL:  d -> ONE (a impossible, ctrl_ready=0); else stay.
//  - Latency: ctrl_fire in cycle N -> outs_valid=1 in cycle N+1. Throughput: 1 token/cycle
//    sustained when outs_ready=1 continuously.
//  - Tokens are never dropped or duplicated: count(outs_fire) = count(ctrl_fire) - occ.
//  - outs_valid, once asserted, stays high until outs_fire (AXI-style stability); outs constant.
//  - tok_count increments by 1 on each outs_fire, wraps from 2^CNT_WIDTH-1 to 0.
//  - ctrl_valid may drop without a transfer; ignored unless ctrl_ready=1 in that cycle.
//  - rst asserted mid-operation: buffered tokens are discarded, outputs return to reset values
//    immediately (async), no outs_fire counted for discarded tokens.
//  - X on ctrl_valid/outs_ready while rst=0 must not corrupt state.
// STRUCTURE
//  - Shared include handshake_defs.vh: occupancy encodings OCC_EMPTY/OCC_ONE/OCC_FULL (2-bit)
//    and the constant-resize macro, reused by other buffered handshake units.
//  - One sub-module: handshake_skid_ctrl (valid/ready + occupancy FSM only, no data path, since
//    data is constant); top adds CONST_VALUE resize and tok_count counter.
// TESTING
//  1 Reset: rst=0 for 3 cycles with ctrl_valid=1 -> outs_valid=0, ctrl_ready=1, tok_count=0,
//    outs=12 (DATA_WIDTH=32).
//  2 Stream: ctrl_valid=1, outs_ready=1 for 100 cycles -> first outs_valid one cycle after
//    first ctrl_fire, then 1 transfer/cycle, tok_count=99 after cycle 100, ctrl_ready never 0.
//  3 Backpressure: outs_ready=0, ctrl_valid=1 -> 2 accepts, then ctrl_ready=0 (FULL);
//    raise outs_ready -> exactly 2 buffered tokens drain then stream resumes, none lost.
//  4 Random valid/ready (10k cycles, 50%/30% density) -> scoreboard: outs_fire count =
//    ctrl_fire count - occ every cycle, outs_valid never drops without outs_fire.
//  5 Wrap: CNT_WIDTH=4, 17 transfers -> tok_count 15 then 0 then 1.
//  6 Mid-op reset: FULL state, pulse rst=0 between edges -> outs_valid=0, ctrl_ready=1
//    immediately; after release, a new token appears 1 cycle after its ctrl_fire, tok_count=1.
//  Also check CONST_VALUE=32'hFFFF_FFFF with DATA_WIDTH=8 -> outs=8'hFF.

Source files
------------

// File: rtl/handshake_constant_buffered_pkg.sv
// Shared definitions for buffered handshake units: occupancy encoding of the
// two-slot elastic buffer and the width of the constant source value.
package handshake_constant_buffered_pkg;

  localparam int CONST_SRC_WIDTH = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/handshake_skid_ctrl.sv
// Valid/ready control of a two-slot skid buffer. There is no data path here;
// both handshake outputs are registered so no input reaches any output combinationally.
module handshake_skid_ctrl
  import handshake_constant_buffered_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ctrl_valid,
  output logic ctrl_ready,
  output logic outs_valid,
  input  logic outs_ready,
  output logic outs_fire
);

  occ_t occ;
  occ_t occ_next;
  logic ctrl_fire;

  assign ctrl_fire = ctrl_valid & ctrl_ready;
  assign outs_fire = outs_valid & outs_ready;

  // The handshake flops are loaded from the next occupancy, so they always agree with occ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ        <= OCC_EMPTY;
      outs_valid <= 1'b0;
      ctrl_ready <= 1'b1;
    end else begin
      occ        <= occ_next;
      outs_valid <= (occ_next != OCC_EMPTY);
      ctrl_ready <= (occ_next != OCC_FULL);
    end
  end

  always_comb begin
    occ_next = occ;
    case (occ)
      OCC_EMPTY: begin
        if (ctrl_fire == 1'b1) occ_next = OCC_ONE;
      end
      OCC_ONE: begin
        if (ctrl_fire == 1'b1 && outs_fire == 1'b0)      occ_next = OCC_FULL;
        else if (ctrl_fire == 1'b0 && outs_fire == 1'b1) occ_next = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (outs_fire == 1'b1) occ_next = OCC_ONE;
      end
      default: occ_next = OCC_EMPTY;
    endcase
  end

endmodule

// File: rtl/handshake_constant_buffered.sv
// Constant handshake source behind a two-slot skid buffer: each accepted control
// token emits one CONST_VALUE word on outs; tok_count tallies output transfers.
module handshake_constant_buffered
  import handshake_constant_buffered_pkg::*;
#(
  parameter int                         DATA_WIDTH  = 32,
  parameter logic [CONST_SRC_WIDTH-1:0] CONST_VALUE = 32'd12,
  parameter int                         CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  tok_count
);

  logic outs_fire;

  handshake_skid_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .outs_fire  (outs_fire)
  );

  // Constant is truncated (LSBs kept) or zero-extended to the output width.
  generate
    if (DATA_WIDTH <= CONST_SRC_WIDTH) begin : g_trunc
      assign outs = CONST_VALUE[DATA_WIDTH-1:0];
    end else begin : g_ext
      assign outs = {{(DATA_WIDTH-CONST_SRC_WIDTH){1'b0}}, CONST_VALUE};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tok_count <= '0;
    else if (outs_fire) tok_count <= tok_count + CNT_WIDTH'(1);
  end

endmodule
